sipo_frame_rx: RTL and testbench

Serial frame receiver that pairs with the team's serial shift-register transmit path. Samples one bit per clock on serial_in and detects a start bit. Shifts in WIDTH data bits MSB-first, checks the stop bit, and presents the word on a parallel output. The word is held behind a valid/ready handshake and flagged for framing and overrun errors.

---
 rtl/sipo_frame_rx.sv | 172 +++++++++++++++++
 tb/tb_sipo_frame_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial frame receiver.
//
// Samples serial_in on every rising edge. A frame is a start bit (1), WIDTH data bits MSB first,
// an optional even-parity bit, and a stop bit (0). A good word is presented on parallel_out behind
// a valid/ready handshake. Framing, parity and overrun problems are reported as one-cycle pulses.
//
// Build option: define PARITY_EN to expect an even-parity bit between the data and the stop bit.
// Without it, there is no parity bit and parity_err is tied to 0.
//
// Parameters:
//   WIDTH        data bits per frame (2..32)
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   serial_in    serial line, idle low
//   out_ready    consumer accepts parallel_out when high together with out_valid
//   parallel_out last good received word
//   out_valid    parallel_out holds an unconsumed word
//   frame_err    one-cycle pulse: stop bit sampled as 1
//   overrun      one-cycle pulse: good frame dropped because the holding register was full
//   parity_err   one-cycle pulse: parity mismatch (PARITY_EN builds only)
//   busy         a frame is in progress
module sipo_frame_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             frame_ok;
    logic             last_bit;

`ifdef PARITY_EN
    logic par_ok_q, par_ok_d;
    logic parity_err_q, parity_err_d;
    assign frame_ok = par_ok_q;
`else
    assign frame_ok = 1'b1;
`endif

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_EN
            par_ok_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef PARITY_EN
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (serial_in) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (last_bit) begin
`ifdef PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: state_d = StStop;
            // Always back to idle: a 1 on the stop slot is an error, never a new start.
            StStop:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        // A consume can happen on any edge, including one that also completes a frame.
        valid_d      = valid_q & ~out_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef PARITY_EN
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
            end
            StData: begin
                shift_d = {shift_q[WIDTH-2:0], serial_in};
                cnt_d   = cnt_q + CntW'(1);
            end
            StParity: begin
`ifdef PARITY_EN
                // Even parity: data XOR parity bit must be 0.
                par_ok_d = ~(^shift_q ^ serial_in);
`endif
            end
            StStop: begin
                if (serial_in) begin
                    frame_err_d = 1'b1;
                end else if (!frame_ok) begin
`ifdef PARITY_EN
                    parity_err_d = 1'b1;
`endif
                end else if (valid_q && !out_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign parallel_out = data_q;
    assign out_valid    = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != StIdle);
`ifdef PARITY_EN
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx. Frames are built from a word plus stop/parity choices, and the
// expected held word, valid flag and error pulses come from a frame-level model of the receiver.
module tb_sipo_frame_rx;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             serial_in = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Frame-level model of the holding register
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_word = '0;

    sipo_frame_rx #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .parity_err   (parity_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, one sample later.
    task automatic drive_bit(input logic b);
        serial_in = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        out_ready = rdy;
        for (int i = 0; i < n; i++) begin
            drive_bit(1'b0);
            if (rdy) m_valid = 1'b0;
            check("idle_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("idle_word", {{(32-WIDTH){1'b0}}, parallel_out}, {{(32-WIDTH){1'b0}}, m_word});
            check("idle_pulses", {29'b0, frame_err, overrun, parity_err}, 32'd0);
            check("idle_busy", {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] word, input logic stop_bit,
                              input logic bad_par, input logic rdy);
        logic par_ok;
        logic good;
        logic exp_ov;
        out_ready = rdy;
        drive_bit(1'b1);
        check("busy_mid", {31'b0, busy}, 32'd1);
        // A waiting word is consumed at the start edge when ready is held high.
        if (rdy) m_valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) drive_bit(word[i]);
`ifdef PARITY_EN
        drive_bit((^word) ^ bad_par);
        par_ok = !bad_par;
`else
        par_ok = 1'b1;
        if (bad_par) par_ok = 1'b1;  // no parity bit on the wire to corrupt
`endif
        drive_bit(stop_bit);
        good   = !stop_bit && par_ok;
        exp_ov = good && m_valid && !rdy;
        if (good && !exp_ov) begin
            m_word  = word;
            m_valid = 1'b1;
        end
        check("frame_err", {31'b0, frame_err}, {31'b0, stop_bit});
        check("parity_err", {31'b0, parity_err}, {31'b0, (!stop_bit && !par_ok)});
        check("overrun", {31'b0, overrun}, {31'b0, exp_ov});
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("parallel_out", {{(32-WIDTH){1'b0}}, parallel_out},
              {{(32-WIDTH){1'b0}}, m_word});
        check("busy_end", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_outputs", {{(32-WIDTH){1'b0}}, parallel_out}, 32'd0);
        check("rst_flags", {27'b0, out_valid, frame_err, overrun, parity_err, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single good frame, consumed after one cycle
        send_frame(4'b1011, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Overrun: second frame dropped while holding register is full
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Bad stop bit, then recovery
        send_frame(4'b1111, 1'b1, 1'b0, 1'b1);
        send_frame(4'b0011, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Back-to-back frames with zero idle
        send_frame(4'b1010, 1'b0, 1'b0, 1'b1);
        send_frame(4'b0101, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Asynchronous reset mid-frame with a word held
        send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_word", {{(32-WIDTH){1'b0}}, parallel_out}, 32'd0);
        check("arst_flags", {27'b0, out_valid, frame_err, overrun, parity_err, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        m_valid = 1'b0;
        m_word  = '0;
        send_frame(4'b1100, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

`ifdef PARITY_EN
        send_frame(4'b1011, 1'b0, 1'b0, 1'b1);
        send_frame(4'b1011, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
`endif

        // Randomized frames, gaps and handshake behaviour
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] w;
            w = WIDTH'($urandom);
            send_frame(w, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
